// File: rtl/lrpt_sync_pkg.sv
// rtl/lrpt_sync_pkg.sv - shared unique-word constants and framer state type
package lrpt_sync_pkg;

  localparam logic [7:0] SYNC_WORD_DEF      = 8'h27;
  localparam int         SYNC_LEN_DEF       = 8;
  localparam int         BITS_PER_FRAME_DEF = 80;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    PAYLOAD
  } uw_ins_state_t;

endpackage

// File: rtl/uw_out_stage.sv
// rtl/uw_out_stage.sv - single-bit output register with sideband and slot_free
module uw_out_stage #(
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             load,
  input  logic             data_d,
  input  logic             valid_d,
  input  logic             sof_d,
  input  logic             fill_d,
  input  logic [IDX_W-1:0] idx_d,
  input  logic             ready_in,
  output logic             data_out,
  output logic             valid_out,
  output logic             sof_out,
  output logic             fill_out,
  output logic [IDX_W-1:0] bit_idx,
  output logic             slot_free
);

  // The register may take a new bit when empty or when downstream drains it.
  assign slot_free = !valid_out || ready_in;

  // Load the whole bit plus sideband together; hold everything otherwise.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      data_out  <= 1'b0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      fill_out  <= 1'b0;
      bit_idx   <= '0;
    end else if (load && slot_free) begin
      data_out  <= data_d;
      valid_out <= valid_d;
      sof_out   <= sof_d;
      fill_out  <= fill_d;
      bit_idx   <= idx_d;
    end
  end

endmodule

// File: rtl/uw_sync_insert.sv
// rtl/uw_sync_insert.sv - unique-word framer; UW_SYNC_FILL_EN enables fill bits on underrun
module uw_sync_insert
  import lrpt_sync_pkg::*;
#(
  parameter int                  BITS_PER_FRAME = BITS_PER_FRAME_DEF,
  parameter int                  SYNC_LEN       = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD      = SYNC_WORD_DEF,
  parameter int                  FRAME_CNT_W    = 16,
  parameter logic                FILL_BIT       = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_in,
  input  logic                              data_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  output logic                              data_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic                              sof_out,
  output logic                              fill_out,
  output logic [$clog2(BITS_PER_FRAME)-1:0] bit_idx,
  output logic [FRAME_CNT_W-1:0]            frame_cnt
);

  localparam int IDX_W = $clog2(BITS_PER_FRAME);
  localparam int SW    = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;

  if (SYNC_LEN >= BITS_PER_FRAME) begin : g_bad_cfg
    $error("uw_sync_insert: SYNC_LEN must be smaller than BITS_PER_FRAME");
  end

  uw_ins_state_t    state, state_nx;
  logic [IDX_W-1:0] pos, pos_nx;
  logic             frame_done;
  logic             slot_free;
  logic             ld, ld_data, ld_valid, ld_sof, ld_fill;
  logic [IDX_W-1:0] ld_idx;
  logic [SW-1:0]    sync_sel;

  // Unique word goes out MSB first; pos is below SYNC_LEN whenever this is used.
  assign sync_sel  = SW'(SYNC_LEN - 1) - SW'(pos);
  assign ready_out = (state == PAYLOAD) && slot_free;

  // State, position and frame counter; a reset drops any partial frame.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      pos       <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      pos   <= pos_nx;
      if (frame_done) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  // Next state and output-stage load values.
  always_comb begin
    state_nx   = state;
    pos_nx     = pos;
    frame_done = 1'b0;
    ld         = 1'b0;
    ld_data    = 1'b0;
    ld_valid   = 1'b0;
    ld_sof     = 1'b0;
    ld_fill    = 1'b0;
    ld_idx     = pos;
    case (state)
      IDLE: begin
        if (valid_in) begin
          state_nx = SYNC;
          pos_nx   = '0;
        end
      end
      SYNC: begin
        if (slot_free) begin
          ld       = 1'b1;
          ld_data  = SYNC_WORD[sync_sel];
          ld_valid = 1'b1;
          ld_sof   = (pos == '0);
          pos_nx   = pos + IDX_W'(1);
          if (pos == IDX_W'(SYNC_LEN - 1)) state_nx = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (slot_free) begin
          ld = 1'b1;
          if (valid_in) begin
            ld_data  = data_in;
            ld_valid = 1'b1;
          end else begin
            // Underrun: the data value is only meaningful when flagged as fill.
            ld_data  = FILL_BIT;
`ifdef UW_SYNC_FILL_EN
            ld_valid = 1'b1;
            ld_fill  = 1'b1;
`else
            ld_valid = 1'b0;
`endif
          end
          // Position advances only for bits actually placed on the stream.
          if (ld_valid) begin
            if (pos == IDX_W'(BITS_PER_FRAME - 1)) begin
              pos_nx     = '0;
              state_nx   = SYNC;
              frame_done = 1'b1;
            end else begin
              pos_nx = pos + IDX_W'(1);
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  uw_out_stage #(.IDX_W(IDX_W)) u_out (
    .clk       (clk),
    .rst_in    (rst_in),
    .load      (ld),
    .data_d    (ld_data),
    .valid_d   (ld_valid),
    .sof_d     (ld_sof),
    .fill_d    (ld_fill),
    .idx_d     (ld_idx),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sof_out   (sof_out),
    .fill_out  (fill_out),
    .bit_idx   (bit_idx),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_uw_sync_insert.sv
// tb/tb_uw_sync_insert.sv - directed vectors and sequences for uw_sync_insert
module tb_uw_sync_insert;

  localparam int FCW = 4;
  localparam int BPF = 80;
  localparam int SL  = 8;

  logic           clk = 1'b0;
  logic           rst_in;
  logic           data_in, valid_in, ready_in;
  logic           ready_out, data_out, valid_out, sof_out, fill_out;
  logic [6:0]     bit_idx;
  logic [FCW-1:0] frame_cnt;

  uw_sync_insert #(.FRAME_CNT_W(FCW)) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .sof_out   (sof_out),
    .fill_out  (fill_out),
    .bit_idx   (bit_idx),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vin, din, rin;
    logic       rdy, vld, dat, sof;
    logic [6:0] idx;
  } vec_t;

  vec_t       vec [17];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] uw = 8'h27;
  logic       q [$];
  int         k = 0;
  int         n_sof = 0;
  bit         mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream-side checker: every consumed bit is matched to its frame slot.
  task automatic monitor();
    int idx_e;
    if (valid_out && ready_in) begin
      idx_e = k % BPF;
      chk("mon_idx", 32'(bit_idx), 32'(idx_e));
      chk("mon_fill", 32'(fill_out), 0);
      if (idx_e < SL) begin
        chk("mon_sync", 32'(data_out), 32'(uw[SL-1-idx_e]));
        chk("mon_sof", 32'(sof_out), 32'(idx_e == 0));
      end else begin
        chk("mon_sof0", 32'(sof_out), 0);
        if (q.size() == 0) chk("mon_underflow", 1, 0);
        else chk("mon_payload", 32'(data_out), 32'(q.pop_front()));
      end
      if (idx_e == BPF - 1) chk("mon_fcnt", 32'(frame_cnt), 32'(((k / BPF) + 1) % (1 << FCW)));
      if (sof_out) n_sof++;
      k++;
    end
    if (valid_in && ready_out) q.push_back(data_in);
  endtask

  task automatic step();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst_in = 1'b1;
    valid_in = 1'b0; data_in = 1'b0; ready_in = 1'b1;
    step(); step();
    rst_in = 1'b0;
    q.delete(); k = 0; n_sof = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  32'(data_out), 0);
    chk({tag, "_valid"}, 32'(valid_out), 0);
    chk({tag, "_sof"},   32'(sof_out), 0);
    chk({tag, "_fill"},  32'(fill_out), 0);
    chk({tag, "_idx"},   32'(bit_idx), 0);
    chk({tag, "_fcnt"},  32'(frame_cnt), 0);
    chk({tag, "_rdy"},   32'(ready_out), 0);
  endtask

  initial begin
    int guard;
    // vin din rin | rdy vld dat sof idx
    vec[0]  = '{1,1,1, 0,0,0,0, 7'd0};
    vec[1]  = '{1,1,1, 0,1,0,1, 7'd0};
    vec[2]  = '{1,1,1, 0,1,0,0, 7'd1};
    vec[3]  = '{1,1,0, 0,1,0,0, 7'd1};
    vec[4]  = '{1,1,1, 0,1,1,0, 7'd2};
    vec[5]  = '{1,1,1, 0,1,0,0, 7'd3};
    vec[6]  = '{0,0,1, 0,1,0,0, 7'd4};
    vec[7]  = '{1,1,1, 0,1,1,0, 7'd5};
    vec[8]  = '{1,1,1, 0,1,1,0, 7'd6};
    vec[9]  = '{1,1,1, 0,1,1,0, 7'd7};
    vec[10] = '{1,1,1, 1,1,1,0, 7'd8};
    vec[11] = '{1,0,0, 0,1,1,0, 7'd8};
    vec[12] = '{1,0,1, 1,1,0,0, 7'd9};
    vec[13] = '{0,0,1, 1,0,0,0, 7'd0};
    vec[14] = '{0,0,0, 1,0,0,0, 7'd0};
    vec[15] = '{1,1,0, 1,1,1,0, 7'd10};
    vec[16] = '{1,0,1, 1,1,0,0, 7'd11};

    rst_in = 1'b1; valid_in = 1'b0; data_in = 1'b0; ready_in = 1'b0;
    step(); step();
    chk_zero("rst");
    rst_in = 1'b0;

    // Vector table from a fresh reset
    for (int i = 0; i < 17; i++) begin
      valid_in = vec[i].vin; data_in = vec[i].din; ready_in = vec[i].rin;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), 32'(ready_out), 32'(vec[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_vld", i), 32'(valid_out), 32'(vec[i].vld));
      chk($sformatf("v%0d_fcnt", i), 32'(frame_cnt), 0);
      if (vec[i].vld) begin
        chk($sformatf("v%0d_dat", i), 32'(data_out), 32'(vec[i].dat));
        chk($sformatf("v%0d_sof", i), 32'(sof_out), 32'(vec[i].sof));
        chk($sformatf("v%0d_idx", i), 32'(bit_idx), 32'(vec[i].idx));
      end
    end

    // Continuous stream: 240 output bits -> 3 frames
    do_reset();
    mon_en = 1; valid_in = 1'b1; ready_in = 1'b1;
    for (int c = 0; c < 241; c++) begin
      data_in = 1'($urandom_range(0, 1));
      step();
    end
    chk("cont_fcnt3", 32'(frame_cnt), 3);
    chk("cont_idx79", 32'(bit_idx), 79);

    // Underrun gap of 5 cycles at pos 20
    guard = 0;
    while (!(valid_out && bit_idx == 7'd19) && guard < 200) begin
      data_in = 1'($urandom_range(0, 1));
      step(); guard++;
    end
    chk("gap_reach19", 32'(guard < 200), 1);
    valid_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("gap_vld%0d", c), 32'(valid_out), 0);
    end
    valid_in = 1'b1; data_in = 1'b1;
    step();
    chk("gap_resume_vld", 32'(valid_out), 1);
    chk("gap_resume_idx", 32'(bit_idx), 20);

    // Asynchronous reset mid-payload at pos 40
    guard = 0;
    while (!(valid_out && bit_idx == 7'd40) && guard < 200) begin
      data_in = 1'($urandom_range(0, 1));
      step(); guard++;
    end
    chk("mid_reach40", 32'(guard < 200), 1);
    mon_en = 0;
    #2 rst_in = 1'b1;
    #1 chk_zero("arst");
    @(posedge clk); #1;
    rst_in = 1'b0;
    q.delete(); k = 0; n_sof = 0;
    valid_in = 1'b1; ready_in = 1'b1; data_in = 1'b1;
    step();
    chk("post_rst_idle", 32'(valid_out), 0);
    mon_en = 1;
    step();
    chk("post_rst_sof", 32'(sof_out), 1);
    chk("post_rst_idx", 32'(bit_idx), 0);
    chk("post_rst_fcnt", 32'(frame_cnt), 0);

    // Random handshakes until 17 frames are consumed -> 4-bit counter wraps to 1
    guard = 0;
    while (k < 17 * BPF && guard < 20000) begin
      valid_in = ($urandom_range(0, 3) != 0);
      data_in  = 1'($urandom_range(0, 1));
      ready_in = 1'($urandom_range(0, 1));
      step(); guard++;
    end
    chk("rand_done", 32'(guard < 20000), 1);
    chk("wrap_fcnt", 32'(frame_cnt), 1);
    chk("wrap_sofs", 32'(n_sof), 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
